serial_adder_seq: RTL
=====================

SERIAL_ADDER_SEQ -- requirements
Module: serial_adder_seq

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 4, meaning the width of the internal ripple-carry adder slice added per cycle.
REQ-002 SHALL have parameter WORDS, default 4, meaning the number of slices per operand; WORDS >= 1.
REQ-003 SHALL derive DATA_WIDTH = WORD_WIDTH*WORDS; it is not an independent parameter.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port din_a, input, DATA_WIDTH, operand A.
REQ-007 SHALL have port din_b, input, DATA_WIDTH, operand B.
REQ-008 SHALL have port din_ci, input, 1, carry-in.
REQ-009 SHALL have port din_vld, input, 1, operands valid.
REQ-010 SHALL have port din_rd, output, 1, block ready to accept operands.
REQ-011 SHALL have port dout_s, output, DATA_WIDTH, the sum.
REQ-012 SHALL have port dout_co, output, 1, carry-out of the top slice.
REQ-013 SHALL have port dout_vld, output, 1, result valid.
REQ-014 SHALL have port dout_rd, input, 1, consumer ready.
REQ-015 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-016 SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-017 SHALL drive din_rd=1 only in IDLE; all other outputs SHALL be registered.
REQ-018 SHALL, in IDLE, accept a transfer on a cycle with din_vld=1 and din_rd=1: latch din_a/din_b into shift registers, load the carry register with din_ci, clear the slice counter, and go to RUN.
REQ-019 SHALL, each RUN cycle, add the low WORD_WIDTH bits of the A and B shift registers plus the carry register using one WORD_WIDTH-bit ripple adder.
REQ-020 SHALL, each RUN cycle, shift the slice sum into the top of the result register, store the slice carry-out in the carry register, shift A and B right by WORD_WIDTH, and increment the counter.
REQ-021 SHALL leave RUN for DONE after exactly WORDS RUN cycles, at counter == WORDS-1.
REQ-022 SHALL, in DONE, drive dout_vld=1 with dout_s = (A+B+ci) mod 2^DATA_WIDTH and dout_co = bit DATA_WIDTH of A+B+ci.
REQ-023 SHALL hold dout_s and dout_co stable while dout_vld=1 and dout_rd=0.
REQ-024 SHALL, in DONE with dout_rd=1, complete the transfer and return to IDLE on the next edge; din_rd is not asserted in that same cycle.
REQ-025 SHALL meet this latency: transfer accepted at edge N gives dout_vld=1 from cycle N+WORDS+1; throughput is one operation per WORDS+2 cycles when dout_rd is held high.
REQ-026 SHALL ignore changes to din_* while not in IDLE.
REQ-027 SHALL, when WORDS=1, spend exactly one cycle in RUN.
REQ-028 SHALL keep dout_s and dout_co at their last result values after leaving DONE, with dout_vld=0.

Reset
REQ-029 SHALL, when rst=1 at a rising edge, go to IDLE in any state, including mid-RUN and DONE with a result pending; a pending result is discarded.
REQ-030 SHALL, after reset, drive dout_vld=0, dout_s=0, dout_co=0, busy=0, din_rd=1, and clear the counter, carry register and shift registers to 0.
REQ-031 SHALL give rst priority over a handshake occurring on the same edge.

Verification
REQ-032 SHALL cover this scenario with defaults: a=0xFFFF, b=0x0001, ci=0 accepted at edge 0 -> dout_vld=1 at cycle 5, s=0x0000, co=1.
REQ-033 SHALL cover this scenario: a=0x1234, b=0x4321, ci=1 -> s=0x5556, co=0; busy=1 during cycles 1..5.
REQ-034 SHALL cover this backpressure scenario: dout_rd=0 for 10 cycles after dout_vld rises -> dout_vld, s and co stable, din_rd=0 throughout; dout_rd=1 -> IDLE on the next edge.
REQ-035 SHALL cover this scenario: rst=1 during the 2nd RUN cycle -> next cycle IDLE, dout_vld=0, s=0, co=0; a following operation 0x0F0F+0x00F1 gives s=0x1000, co=0.
REQ-036 SHALL cover this scenario: 1000 random a/b/ci with random din_vld/dout_rd, at defaults and at WORD_WIDTH=8, WORDS=1 -> every result equals a+b+ci exactly; no lost or duplicated transfers.

Source files
------------

// File: rtl/serial_adder_seq.sv
// rtl/serial_adder_seq.sv - multi-cycle adder that adds WORD_WIDTH-bit slices per clock
//
// Adds two DATA_WIDTH operands plus a carry-in by running one WORD_WIDTH-bit
// adder over WORDS consecutive clocks, least-significant slice first.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset
//   din_a    - operand A (DATA_WIDTH)
//   din_b    - operand B (DATA_WIDTH)
//   din_ci   - carry-in
//   din_vld  - operands valid
//   din_rd   - block ready to accept operands (IDLE only)
//   dout_s   - sum (DATA_WIDTH), holds the last result
//   dout_co  - carry-out of the top slice, holds the last result
//   dout_vld - result valid (DONE)
//   dout_rd  - consumer ready
//   busy     - high whenever not IDLE
module serial_adder_seq #(
  parameter int WORD_WIDTH = 4,
  parameter int WORDS      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WORD_WIDTH*WORDS-1:0]   din_a,
  input  logic [WORD_WIDTH*WORDS-1:0]   din_b,
  input  logic                          din_ci,
  input  logic                          din_vld,
  output logic                          din_rd,
  output logic [WORD_WIDTH*WORDS-1:0]   dout_s,
  output logic                          dout_co,
  output logic                          dout_vld,
  input  logic                          dout_rd,
  output logic                          busy
);

  localparam int DATA_WIDTH = WORD_WIDTH * WORDS;
  // A one-slice configuration still needs a 1-bit counter.
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [DATA_WIDTH-1:0]   a_sr;
  logic [DATA_WIDTH-1:0]   b_sr;
  logic [DATA_WIDTH-1:0]   res_q;
  logic [DATA_WIDTH-1:0]   res_next;
  logic                    carry_q;
  logic [CW-1:0]           cnt_q;
  logic [WORD_WIDTH:0]     slice;

  // One WORD_WIDTH-bit adder shared by every slice; bit WORD_WIDTH is the slice carry.
  assign slice = {1'b0, a_sr[WORD_WIDTH-1:0]}
               + {1'b0, b_sr[WORD_WIDTH-1:0]}
               + {{WORD_WIDTH{1'b0}}, carry_q};

  // New slice enters at the top; after WORDS shifts the low slice sits at bit 0.
  assign res_next = (res_q >> WORD_WIDTH)
                  | (DATA_WIDTH'(slice[WORD_WIDTH-1:0]) << (DATA_WIDTH - WORD_WIDTH));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (din_vld)       state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    if (dout_rd)       state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Output decode straight from the state register, so no combinational input paths.
  always_comb begin
    din_rd   = (state_q == IDLE);
    busy     = (state_q != IDLE);
    dout_vld = (state_q == DONE);
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      dout_s  <= '0;
      dout_co <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (din_vld) begin
            a_sr    <= din_a;
            b_sr    <= din_b;
            carry_q <= din_ci;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          a_sr    <= a_sr >> WORD_WIDTH;
          b_sr    <= b_sr >> WORD_WIDTH;
          carry_q <= slice[WORD_WIDTH];
          res_q   <= res_next;
          cnt_q   <= cnt_q + CW'(1);
          // Result outputs only change on the final slice, so they stay put
          // through DONE, IDLE and the next operation's RUN cycles.
          if (cnt_q == LAST) begin
            dout_s  <= res_next;
            dout_co <= slice[WORD_WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
